// File: rtl/iter_root.sv
// iter_root: iterative floor square / cube root with remainder.
// One result digit is resolved every two cycles (PREP forms the trial
// subtrahend, TEST conditionally subtracts it). The operand register x is
// reduced in place, so at completion it already holds the remainder.
module iter_root #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] x_in,
  output logic [WIDTH-1:0] root,
  output logic [WIDTH-1:0] rem,
  output logic             ready,
  output logic             busy
);

  // Internal width for the trial value: the worst-case cube trial term,
  // (3v(v+1)+1) shifted into place, stays below 2^(WIDTH+3), so four extra
  // bits keep it exact and an oversize trial simply fails the compare.
  localparam int WB    = WIDTH + 4;
  // Digit counts and starting shifts for both modes.
  localparam int N_SQ  = (WIDTH + 1) / 2;
  localparam int N_CU  = (WIDTH + 2) / 3;
  localparam int S0_SQ = 2 * (N_SQ - 1);
  localparam int S0_CU = 3 * (N_CU - 1);
  // Shift amount never exceeds WIDTH-1.
  localparam int SW    = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    TEST = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] x_reg, x_next;
  logic [WIDTH-1:0] y_reg, y_next;
  logic             m_reg, m_next;
  logic [SW-1:0]    s_reg, s_next;
  logic [WB-1:0]    b_reg, b_next;
  logic [WIDTH-1:0] root_reg, root_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic             ready_reg, ready_next;
  logic             busy_reg, busy_next;

  // Datapath helpers
  logic [WB-1:0]    v_ext;     // 2y, widened
  logic [WB-1:0]    p_sq;      // 2v+1
  logic [WB-1:0]    p_cu;      // 3v(v+1)+1
  logic [WB-1:0]    p_sel;
  logic [WB-1:0]    b_shift;
  logic             x_ge_b;
  logic [WIDTH-1:0] x_sub;
  logic             s_last;
  logic [SW-1:0]    k_sel;

  assign root  = root_reg;
  assign rem   = rem_reg;
  assign ready = ready_reg;
  assign busy  = busy_reg;

  // Trial term P(2y) << s, and the compare/subtract of the current step.
  always_comb begin
    v_ext   = WB'(y_reg) << 1;
    p_sq    = (v_ext << 1) + WB'(1);
    p_cu    = WB'(3) * v_ext * (v_ext + WB'(1)) + WB'(1);
    p_sel   = m_reg ? p_cu : p_sq;
    b_shift = p_sel << s_reg;
    x_ge_b  = (WB'(x_reg) >= b_reg);
    // Only used when b fits below x, so the low bits are the full value.
    x_sub   = x_reg - b_reg[WIDTH-1:0];
    k_sel   = m_reg ? SW'(3) : SW'(2);
    s_last  = (s_reg < k_sel);
  end

  // Next-state and next-register logic for the control FSM and datapath.
  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    m_next     = m_reg;
    s_next     = s_reg;
    b_next     = b_reg;
    root_next  = root_reg;
    rem_next   = rem_reg;
    ready_next = 1'b0;
    busy_next  = busy_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          x_next     = x_in;
          m_next     = mode;
          y_next     = '0;
          s_next     = mode ? SW'(S0_CU) : SW'(S0_SQ);
          busy_next  = 1'b1;
          state_next = PREP;
        end
      end
      PREP: begin
        y_next     = y_reg << 1;
        b_next     = b_shift;
        state_next = TEST;
      end
      TEST: begin
        if (x_ge_b) begin
          x_next = x_sub;
          y_next = y_reg + WIDTH'(1);
        end
        if (s_last) begin
          state_next = DONE;
        end else begin
          s_next     = s_reg - k_sel;
          state_next = PREP;
        end
      end
      DONE: begin
        root_next  = y_reg;
        rem_next   = x_reg;
        ready_next = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything immediately and
  // abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      m_reg     <= 1'b0;
      s_reg     <= '0;
      b_reg     <= '0;
      root_reg  <= '0;
      rem_reg   <= '0;
      ready_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      m_reg     <= m_next;
      s_reg     <= s_next;
      b_reg     <= b_next;
      root_reg  <= root_next;
      rem_reg   <= rem_next;
      ready_reg <= ready_next;
      busy_reg  <= busy_next;
    end
  end

endmodule

// File: tb/tb_iter_root.sv
// tb_iter_root: self-checking bench for iter_root at WIDTH=16 and WIDTH=8,
// comparing against a brute-force floor-root reference model.
module tb_iter_root;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start16 = 1'b0, mode16 = 1'b0;
  logic [15:0] x16 = '0, root16, rem16;
  logic        ready16, busy16;

  logic        start8 = 1'b0, mode8 = 1'b0;
  logic [7:0]  x8 = '0, root8, rem8;
  logic        ready8, busy8;

  int checks_total  = 0;
  int checks_passed = 0;

  iter_root #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .mode(mode16), .x_in(x16),
    .root(root16), .rem(rem16), .ready(ready16), .busy(busy16)
  );

  iter_root #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8), .x_in(x8),
    .root(root8), .rem(rem8), .ready(ready8), .busy(busy8)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    checks_total++;
    if (obs == exp) checks_passed++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Reference: smallest search for r with r^K <= x < (r+1)^K.
  function automatic longint pw(input longint v, input bit md);
    return md ? v * v * v : v * v;
  endfunction

  function automatic void ref_model(input bit md, input longint xv,
                                    output longint r, output longint rm);
    r = 0;
    while (pw(r + 1, md) <= xv) r++;
    rm = xv - pw(r, md);
  endfunction

  // Expected start-to-ready latency: 2*ceil(w/K)+1.
  function automatic int lat_exp(input int w, input bit md);
    int k;
    k = md ? 3 : 2;
    return 2 * ((w + k - 1) / k) + 1;
  endfunction

  function automatic bit cur_ready(input int w);
    return (w == 16) ? ready16 : ready8;
  endfunction

  function automatic bit cur_busy(input int w);
    return (w == 16) ? busy16 : busy8;
  endfunction

  // One handshake transaction; returns result, latency and busy cycle count.
  task automatic do_op(input int w, input bit md, input int xv,
                       output int r, output int rm, output int lat, output int bcnt);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    if (w == 16) begin start16 = 1'b1; mode16 = md; x16 = xv[15:0]; end
    else         begin start8  = 1'b1; mode8  = md; x8  = xv[7:0];  end
    @(posedge clk); #1;
    start16 = 1'b0;
    start8  = 1'b0;
    lat = 0; bcnt = 0; r = -1; rm = -1;
    if (cur_busy(w)) bcnt++;
    while (lat < 200 && !seen) begin
      @(posedge clk); #1;
      lat++;
      if (cur_ready(w)) begin
        seen = 1'b1;
        r  = (w == 16) ? int'(root16) : int'(root8);
        rm = (w == 16) ? int'(rem16)  : int'(rem8);
        check_val("busy_at_ready", longint'(cur_busy(w)), 0);
      end else if (cur_busy(w)) begin
        bcnt++;
      end
    end
    if (!seen) check_val("ready_timeout", 0, 1);
    @(posedge clk); #1;
    check_val("ready_one_cycle", longint'(cur_ready(w)), 0);
    $display("op w=%0d mode=%0d x=%0d -> root=%0d rem=%0d lat=%0d", w, md, xv, r, rm, lat);
  endtask

  // Directed operation with explicit expected values.
  task automatic directed(input int w, input bit md, input int xv, input int er, input int erm);
    int r, rm, lat, bcnt;
    do_op(w, md, xv, r, rm, lat, bcnt);
    check_val("dir_root", r, er);
    check_val("dir_rem", rm, erm);
    check_val("dir_latency", lat, lat_exp(w, md));
    check_val("dir_busy_cycles", bcnt, lat_exp(w, md));
  endtask

  // Random operation checked against the reference model.
  task automatic random_op(input int w);
    int r, rm, lat, bcnt, xv;
    bit md;
    longint er, erm;
    md = 1'($urandom_range(0, 1));
    xv = (w == 16) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 255));
    ref_model(md, xv, er, erm);
    do_op(w, md, xv, r, rm, lat, bcnt);
    check_val("rnd_root", r, er);
    check_val("rnd_rem", rm, erm);
    check_val("rnd_latency", lat, lat_exp(w, md));
  endtask

  // All 256 operands with start held high on the 8-bit unit.
  task automatic sweep8(input bit md);
    int idx, edge_cnt, last_edge, guard;
    longint er, erm;
    idx = 0; edge_cnt = 0; last_edge = -1; guard = 0;
    @(negedge clk);
    mode8 = md; x8 = 8'd0; start8 = 1'b1;
    while (idx < 256 && guard < 20000) begin
      @(posedge clk); #1;
      edge_cnt++; guard++;
      if (ready8) begin
        ref_model(md, idx, er, erm);
        check_val("sweep_root", root8, er);
        check_val("sweep_rem", rem8, erm);
        if (last_edge >= 0) check_val("sweep_spacing", edge_cnt - last_edge, lat_exp(8, md) + 1);
        $display("sweep mode=%0d x=%0d -> root=%0d rem=%0d", md, idx, root8, rem8);
        last_edge = edge_cnt;
        idx++;
        if (idx < 256) x8 = idx[7:0];
        else start8 = 1'b0;
      end
    end
    if (idx < 256) check_val("sweep_timeout", idx, 256);
    start8 = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int rcnt, r_cap, rm_cap;

    // Reset state
    #3;
    check_val("rst_root16", root16, 0);
    check_val("rst_rem16", rem16, 0);
    check_val("rst_ready16", ready16, 0);
    check_val("rst_busy16", busy16, 0);
    check_val("rst_root8", root8, 0);
    check_val("rst_rem8", rem8, 0);
    check_val("rst_ready8", ready8, 0);
    check_val("rst_busy8", busy8, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    directed(16, 1'b1, 27000, 30, 0);
    directed(16, 1'b1, 65535, 40, 1535);
    directed(16, 1'b0, 65535, 255, 510);
    directed(8, 1'b0, 200, 14, 4);
    directed(8, 1'b1, 255, 6, 39);
    directed(8, 1'b0, 0, 0, 0);
    directed(8, 1'b1, 0, 0, 0);

    // Start while busy is ignored
    @(negedge clk);
    start16 = 1'b1; mode16 = 1'b0; x16 = 16'd100;
    @(posedge clk); #1;
    start16 = 1'b0;
    rcnt = 0; r_cap = -1; rm_cap = -1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 2) begin start16 = 1'b1; mode16 = 1'b1; x16 = 16'd8; end
      if (cyc == 3) start16 = 1'b0;
      if (ready16) begin rcnt++; r_cap = root16; rm_cap = rem16; end
    end
    check_val("busy_ign_ready_count", rcnt, 1);
    check_val("busy_ign_root", r_cap, 10);
    check_val("busy_ign_rem", rm_cap, 0);
    $display("busy-start op -> root=%0d rem=%0d readies=%0d", r_cap, rm_cap, rcnt);

    // Asynchronous reset mid-operation
    @(negedge clk);
    start16 = 1'b1; mode16 = 1'b1; x16 = 16'd1000;
    @(posedge clk); #1;
    start16 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_val("pre_rst_busy", busy16, 1);
    check_val("pre_rst_root", root16, 10);
    rst = 1'b1;
    #1;
    check_val("async_rst_root", root16, 0);
    check_val("async_rst_rem", rem16, 0);
    check_val("async_rst_busy", busy16, 0);
    check_val("async_rst_ready", ready16, 0);
    #4;
    rst = 1'b0;
    rcnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready16) rcnt++;
    end
    check_val("no_ready_after_rst", rcnt, 0);
    $display("reset mid-op -> readies afterwards=%0d", rcnt);
    directed(16, 1'b1, 1000, 10, 0);

    // Randomized operations
    repeat (30) random_op(16);
    repeat (20) random_op(8);

    // Exhaustive back-to-back sweeps
    sweep8(1'b0);
    sweep8(1'b1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
